// File: rtl/fixed_point_pkg.sv
// Shared fixed-point arithmetic package: FSM encoding,
// quotient width, saturation constants, magnitude helper.
package fixed_point_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Quotient magnitude bits.
  function automatic int calc_dw(input int w, input int d);
    return w + d;
  endfunction

  // +(2^(2w-1)-1), Q bit pattern for x/0 with x >= 0.
  function automatic logic [63:0] sat_pos(input int w);
    return (64'd1 << (2 * w - 1)) - 64'd1;
  endfunction

  // -(2^(2w-1)-1) in 2w bits, Q bit pattern for x/0 with x < 0.
  function automatic logic [63:0] sat_neg(input int w);
    return (64'd1 << (2 * w - 1)) + 64'd1;
  endfunction

  // |v| of a w-bit two's complement value held in v[w-1:0].
  // The result is w bits wide, so |-2^(w-1)| is exact.
  function automatic logic [63:0] mag_of(
    input logic [63:0] v,
    input int          w
  );
    logic [63:0] m;
    m = v[w-1] ? (~v + 64'd1) : v;
    return m & ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/fixed_point_div_if.sv
// Divider request/result bundle.
// master: start/A/B/Conf_Bit_Mask out; slave: busy/done/div_by_zero/Q out.
interface fixed_point_div_if #(
  parameter int WIDTH = 8
);
  logic                      start;
  logic signed [WIDTH-1:0]   A;
  logic signed [WIDTH-1:0]   B;
  logic [WIDTH-3:0]          Conf_Bit_Mask;
  logic                      busy;
  logic                      done;
  logic                      div_by_zero;
  logic signed [2*WIDTH-1:0] Q;

  modport master (
    output start, A, B, Conf_Bit_Mask,
    input  busy, done, div_by_zero, Q
  );

  modport slave (
    input  start, A, B, Conf_Bit_Mask,
    output busy, done, div_by_zero, Q
  );
endinterface

// File: rtl/restoring_div_step.sv
// One restoring-division iteration (combinational).
// in: rem, nbit, magb; out: rem_out, qbit.
module restoring_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             nbit,
  input  logic [WIDTH-1:0] magb,
  output logic [WIDTH-1:0] rem_out,
  output logic             qbit
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] magb_x;

  assign rem_sh = {rem, nbit};
  assign magb_x = {1'b0, magb};
  assign qbit   = (rem_sh >= magb_x);

  // A kept remainder is < magb, so its top bit is zero.
  assign rem_out = qbit
    ? WIDTH'(rem_sh - magb_x)
    : rem_sh[WIDTH-1:0];

endmodule

// File: rtl/fixed_point_div.sv
// Iterative signed fixed-point divider, Q = A / B, one bit/cycle.
// Ports: clk, rst_n (async low), bus (fixed_point_div_if.slave).
module fixed_point_div
  import fixed_point_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEC_POINT_POS = 4
) (
  input  logic clk,
  input  logic rst_n,
  fixed_point_div_if.slave bus
);

  localparam int DW = calc_dw(WIDTH, DEC_POINT_POS);
  localparam int CW = $clog2(DW + 1);
  localparam int QW = 2 * WIDTH;
  localparam int MW = WIDTH - 2;

  localparam logic [QW-1:0] SAT_P =
    QW'(sat_pos(WIDTH));
  localparam logic [QW-1:0] SAT_N =
    QW'(sat_neg(WIDTH));

  div_state_e state_q;
  div_state_e state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [DW-1:0]    dvd_q;
  logic [DW-2:0]    quo_q;
  logic [WIDTH-1:0] magb_q;
  logic             sign_q;
  logic [MW-1:0]    mask_q;
  logic [QW-1:0]    q_q;
  logic             dbz_q;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             b_zero;
  logic             accept;
  logic             last;

  logic [WIDTH-1:0] rem_nx;
  logic             qbit;
  logic [DW-1:0]    qmag;
  logic [DW-1:0]    qmag_m;
  logic [QW-1:0]    q_ext;
  logic [QW-1:0]    q_res;

  assign mag_a = WIDTH'(
    mag_of(64'(unsigned'(bus.A)), WIDTH));
  assign mag_b = WIDTH'(
    mag_of(64'(unsigned'(bus.B)), WIDTH));
  assign b_zero = (mag_b == '0);

  restoring_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem     (rem_q),
    .nbit    (dvd_q[DW-1]),
    .magb    (magb_q),
    .rem_out (rem_nx),
    .qbit    (qbit)
  );

  // Full quotient including this cycle's bit; only the low
  // WIDTH-2 bits are subject to the precision mask.
  assign qmag   = {quo_q, qbit};
  assign qmag_m = qmag & {{(DW-MW){1'b1}}, mask_q};
  assign q_ext  = {{(QW-DW){1'b0}}, qmag_m};
  assign q_res  = sign_q ? (~q_ext + 1'b1) : q_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = b_zero ? DONE : DIV;
        end
      end
      DIV: begin
        if (cnt_q == CW'(1)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      dvd_q  <= '0;
      quo_q  <= '0;
      magb_q <= '0;
      sign_q <= 1'b0;
      mask_q <= '0;
      q_q    <= '0;
      dbz_q  <= 1'b0;
    end else if (accept) begin
      cnt_q  <= CW'(DW);
      rem_q  <= '0;
      dvd_q  <= DW'(mag_a) << DEC_POINT_POS;
      quo_q  <= '0;
      magb_q <= mag_b;
      sign_q <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
      mask_q <= bus.Conf_Bit_Mask;
      if (b_zero) begin
        q_q   <= bus.A[WIDTH-1] ? SAT_N : SAT_P;
        dbz_q <= 1'b1;
      end
    end else if (state_q == DIV) begin
      cnt_q <= cnt_q - 1'b1;
      rem_q <= rem_nx;
      dvd_q <= {dvd_q[DW-2:0], 1'b0};
      quo_q <= qmag[DW-2:0];
      if (last) begin
        q_q   <= q_res;
        dbz_q <= 1'b0;
      end
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.div_by_zero = dbz_q;
  assign bus.Q           = q_q;

endmodule

// File: tb/tb_fixed_point_div.sv
// Scoreboard bench for fixed_point_div (WIDTH=8, DEC_POINT_POS=4).
// Stimulus pushes expected results; a negedge monitor checks them.
module tb_fixed_point_div;

  localparam int W  = 8;
  localparam int DW = 12;

  typedef struct {
    logic [15:0] q;
    logic        z;
    int          cyc;
    int          tol;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  logic prev_done;
  exp_t sb[$];

  fixed_point_div_if #(.WIDTH(W)) bus ();

  fixed_point_div #(
    .WIDTH         (W),
    .DEC_POINT_POS (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done) begin
      chk("done_width", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("Q", {16'd0, bus.Q}, {16'd0, e.q});
        chk("div_by_zero", {31'd0, bus.div_by_zero},
            {31'd0, e.z});
        chk("latency",
            {31'd0, (cyc >= e.cyc) && (cyc <= e.cyc + e.tol)},
            32'd1);
        if (cyc < e.cyc || cyc > e.cyc + e.tol)
          $display("  done at cycle %0d, due %0d", cyc, e.cyc);
      end
    end
    prev_done <= rst_n && bus.done;
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.busy || bus.done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(
    input logic [7:0]  a,
    input logic [7:0]  b,
    input logic [5:0]  m,
    input logic [15:0] q,
    input logic        z
  );
    exp_t e;
    wait_idle();
    bus.A = a;
    bus.B = b;
    bus.Conf_Bit_Mask = m;
    bus.start = 1'b1;
    e.q   = q;
    e.z   = z;
    e.cyc = cyc + 1 + (z ? 0 : DW);
    e.tol = z ? 1 : 0;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = 8'h5A;
    bus.B = 8'hA5;
    bus.Conf_Bit_Mask = 6'h00;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int e0;
    exp_t x;
    checks    = 0;
    failures  = 0;
    prev_done = 1'b0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Conf_Bit_Mask = '0;
    repeat (3) @(negedge clk);
    chk("rst_Q", {16'd0, bus.Q}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(8'h30, 8'h10, 6'h3F, 16'h0030, 1'b0);
    issue(8'hD0, 8'h20, 6'h3F, 16'hFFE8, 1'b0);
    issue(8'h10, 8'h30, 6'h3F, 16'h0005, 1'b0);
    issue(8'h10, 8'h30, 6'h3E, 16'h0004, 1'b0);
    issue(8'h80, 8'hFF, 6'h3F, 16'h0800, 1'b0);
    issue(8'hF0, 8'h00, 6'h3F, 16'h8001, 1'b1);
    issue(8'h7F, 8'h01, 6'h3F, 16'h07F0, 1'b0);
    issue(8'h00, 8'h00, 6'h3F, 16'h7FFF, 1'b1);
    issue(8'h7F, 8'h80, 6'h3F, 16'hFFF1, 1'b0);
    issue(8'h7F, 8'h01, 6'h00, 16'h07C0, 1'b0);
    issue(8'h00, 8'hF0, 6'h3F, 16'h0000, 1'b0);
    issue(8'h10, 8'hD0, 6'h3E, 16'hFFFC, 1'b0);
    drain();

    wait_idle();
    bus.A = 8'h30;
    bus.B = 8'h10;
    bus.Conf_Bit_Mask = 6'h3F;
    bus.start = 1'b1;
    e0 = cyc + 1;
    x.q = 16'h0030; x.z = 1'b0; x.cyc = e0 + 12; x.tol = 0;
    sb.push_back(x);
    @(negedge clk);
    bus.A = 8'h10;
    bus.B = 8'h30;
    x.q = 16'h0005; x.cyc = e0 + 26;
    sb.push_back(x);
    x.cyc = e0 + 40;
    sb.push_back(x);
    while (cyc < e0 + 28) @(negedge clk);
    bus.start = 1'b0;
    drain();

    issue(8'hF0, 8'h00, 6'h3F, 16'h8001, 1'b1);
    drain();
    wait_idle();
    bus.A = 8'h30;
    bus.B = 8'h10;
    bus.Conf_Bit_Mask = 6'h3F;
    bus.start = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    do begin
      @(posedge clk);
      #1;
    end while (cyc < e0 + 5);
    chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_Q", {16'd0, bus.Q}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
    chk("mid_rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("post_rst_Q", {16'd0, bus.Q}, 32'd0);
    issue(8'hD0, 8'h20, 6'h3F, 16'hFFE8, 1'b0);
    drain();

    while (sb.size() != 0) begin
      x = sb.pop_front();
      chk("missing_done", 32'd1, 32'd0);
    end
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
